// File: rtl/adder_bist_pkg.sv
// Shared types for the exhaustive adder BIST: controller state encoding and a busy-decode helper.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic is_run_state(state_e st);
        return (st == ST_DRIVE) || (st == ST_SETTLE) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/adder_bist_vecgen.sv
// Vector counter for the adder BIST: index register, last-vector flag and the
// a/b/c_in split of the next index (a outermost, c_in innermost).
module adder_bist_vecgen
    import adder_bist_pkg::*;
#(
    parameter int unsigned NUMBITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic               last_c,
    output logic [NUMBITS-1:0] a_nxt_c,
    output logic [NUMBITS-1:0] b_nxt_c,
    output logic               c_in_nxt_c
);

    localparam int unsigned VW = 2 * NUMBITS + 1;

    logic [VW-1:0] idx_q;
    logic [VW-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Operands are split from the upcoming index so the top can register them on DRIVE entry.
    assign last_c                          = (idx_q == {VW{1'b1}});
    assign {a_nxt_c, b_nxt_c, c_in_nxt_c}  = idx_d;

endmodule

// File: rtl/adder_bist.sv
// Exhaustive built-in self test for a NUMBITS-wide adder with carry-in/out.
// Optional first-failure log enabled by defining ADDER_BIST_FAILLOG_EN.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned NUMBITS       = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [NUMBITS-1:0]   a,
    output logic [NUMBITS-1:0]   b,
    output logic                 c_in,
    input  logic [NUMBITS-1:0]   s,
    input  logic                 c_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*NUMBITS+1:0] error_count
`ifdef ADDER_BIST_FAILLOG_EN
    ,
    output logic                 fail_valid,
    output logic [NUMBITS-1:0]   fail_a,
    output logic [NUMBITS-1:0]   fail_b,
    output logic                 fail_cin,
    output logic [NUMBITS:0]     fail_expected,
    output logic [NUMBITS:0]     fail_observed
`endif
);

    localparam int unsigned EW  = 2 * NUMBITS + 2;
    localparam int unsigned SW  = NUMBITS + 1;
    localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [SCW-1:0]     settle_q, settle_d;
    logic [EW-1:0]      err_q, err_d;
    logic [NUMBITS-1:0] a_q, a_d, b_q, b_d;
    logic               c_in_q, c_in_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic               vg_clr, vg_inc, vg_last_c, vg_c_in_c;
    logic [NUMBITS-1:0] vg_a_c, vg_b_c;
    logic [SW-1:0]      exp_sum_c, obs_sum_c;
    logic               mismatch_c;

`ifdef ADDER_BIST_FAILLOG_EN
    logic               fail_valid_q, fail_valid_d;
    logic [NUMBITS-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic               fail_cin_q, fail_cin_d;
    logic [SW-1:0]      fail_exp_q, fail_exp_d, fail_obs_q, fail_obs_d;
`endif

    adder_bist_vecgen #(.NUMBITS(NUMBITS)) u_vecgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (vg_clr),
        .inc        (vg_inc),
        .last_c     (vg_last_c),
        .a_nxt_c    (vg_a_c),
        .b_nxt_c    (vg_b_c),
        .c_in_nxt_c (vg_c_in_c)
    );

    assign exp_sum_c  = SW'(a_q) + SW'(b_q) + SW'(c_in_q);
    assign obs_sum_c  = {c_out, s};
    assign mismatch_c = (obs_sum_c != exp_sum_c);

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        c_in_d   = c_in_q;
        vg_clr   = 1'b0;
        vg_inc   = 1'b0;
`ifdef ADDER_BIST_FAILLOG_EN
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_cin_d   = fail_cin_q;
        fail_exp_d   = fail_exp_q;
        fail_obs_d   = fail_obs_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    err_d   = '0;
                    vg_clr  = 1'b1;
                    a_d     = vg_a_c;
                    b_d     = vg_b_c;
                    c_in_d  = vg_c_in_c;
`ifdef ADDER_BIST_FAILLOG_EN
                    fail_valid_d = 1'b0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                    fail_cin_d   = 1'b0;
                    fail_exp_d   = '0;
                    fail_obs_d   = '0;
`endif
                end
            end
            ST_DRIVE: begin
                settle_d = '0;
                state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + EW'(1);
`ifdef ADDER_BIST_FAILLOG_EN
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_a_d     = a_q;
                        fail_b_d     = b_q;
                        fail_cin_d   = c_in_q;
                        fail_exp_d   = exp_sum_c;
                        fail_obs_d   = obs_sum_c;
                    end
`endif
                end
                if (vg_last_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    vg_inc  = 1'b1;
                    a_d     = vg_a_c;
                    b_d     = vg_b_c;
                    c_in_d  = vg_c_in_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = is_run_state(state_d);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            err_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_in_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_in_q   <= c_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

`ifdef ADDER_BIST_FAILLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_cin_q   <= 1'b0;
            fail_exp_q   <= '0;
            fail_obs_q   <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_cin_q   <= fail_cin_d;
            fail_exp_q   <= fail_exp_d;
            fail_obs_q   <= fail_obs_d;
        end
    end

    assign fail_valid    = fail_valid_q;
    assign fail_a        = fail_a_q;
    assign fail_b        = fail_b_q;
    assign fail_cin      = fail_cin_q;
    assign fail_expected = fail_exp_q;
    assign fail_observed = fail_obs_q;
`endif

    assign a           = a_q;
    assign b           = b_q;
    assign c_in        = c_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign error_count = err_q;

endmodule
